// File: rtl/matmul_systolic_engine.sv
// Output-stationary systolic matrix multiplier: C = A*B or C += A*B on signed
// operands up to MAX_DIM x MAX_DIM, with skewed edge feed and sticky overflow flags.
module matmul_systolic_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 32,
  parameter int DIM_W      = 3,
  localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     start_i,
  input  logic                                     accumulate_i,
  input  logic [DIM_W-1:0]                         n_dim_i,
  input  logic [DIM_W-1:0]                         k_dim_i,
  input  logic [DIM_W-1:0]                         m_dim_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]    a_matrix_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0]    b_matrix_i,
  output logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0]  c_matrix_o,
  output logic [MAX_DIM*MAX_DIM-1:0]               flags_o,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     err_o
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(3 * MAX_DIM);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]             state_q;
  logic [CNT_W-1:0]       t_q;
  logic [CNT_W-1:0]       last_q;
  logic [DIM_W-1:0]       n_q, k_q, m_q;
  logic                   err_q;
  logic                   dims_legal;
  logic                   start_accept;

  logic signed [DATA_WIDTH-1:0] a_q      [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] b_q      [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] a_pipe_q [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] b_pipe_q [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0] row_feed_d [MAX_DIM];
  logic signed [DATA_WIDTH-1:0] col_feed_d [MAX_DIM];
  logic signed [ACC_W-1:0]      acc_q    [MAX_DIM][MAX_DIM];
  logic signed [ACC_W-1:0]      prod     [MAX_DIM][MAX_DIM];
  logic signed [ACC_W-1:0]      sum      [MAX_DIM][MAX_DIM];
  logic [MAX_DIM-1:0]           ovf      [MAX_DIM];
  logic [MAX_DIM-1:0]           flag_q   [MAX_DIM];

  assign dims_legal = (n_dim_i != '0) && (int'(n_dim_i) <= MAX_DIM) &&
                      (k_dim_i != '0) && (int'(k_dim_i) <= MAX_DIM) &&
                      (m_dim_i != '0) && (int'(m_dim_i) <= MAX_DIM);
  assign start_accept = (state_q == ST_IDLE) && start_i;

  assign busy_o = (state_q == ST_COMPUTE);
  assign done_o = (state_q == ST_DONE);
  assign err_o  = (state_q == ST_DONE) && err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      last_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            n_q     <= n_dim_i;
            k_q     <= k_dim_i;
            m_q     <= m_dim_i;
            err_q   <= !dims_legal;
            t_q     <= '0;
            last_q  <= CNT_W'(int'(n_dim_i) + int'(m_dim_i) + int'(k_dim_i) - 2);
            state_q <= dims_legal ? ST_COMPUTE : ST_DONE;
          end
        end
        ST_COMPUTE: begin
          if (t_q == last_q) state_q <= ST_DONE;
          else               t_q     <= t_q + 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        for (int unsigned k = 0; k < MAX_DIM; k++) begin
          a_q[i][k] <= '0;
          b_q[i][k] <= '0;
        end
      end
    end else if (start_accept) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        for (int unsigned k = 0; k < MAX_DIM; k++) begin
          a_q[i][k] <= a_matrix_i[(i*MAX_DIM+k)*DATA_WIDTH +: DATA_WIDTH];
          b_q[i][k] <= b_matrix_i[(i*MAX_DIM+k)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Skewed edge feed: row i carries A[i][t-i], column j carries B[t-j][j].
  always_comb begin
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      row_feed_d[i] = '0;
      col_feed_d[i] = '0;
    end
    if (state_q == ST_COMPUTE) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        for (int unsigned k = 0; k < MAX_DIM; k++) begin
          if (i < 32'(n_q) && k < 32'(k_q) && 32'(t_q) == i + k)
            row_feed_d[i] = a_q[i][k];
          if (i < 32'(m_q) && k < 32'(k_q) && 32'(t_q) == i + k)
            col_feed_d[i] = b_q[k][i];
        end
      end
    end
  end

  // Column 0 of a_pipe_q / row 0 of b_pipe_q are the edge feed registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        for (int unsigned j = 0; j < MAX_DIM; j++) begin
          a_pipe_q[i][j] <= '0;
          b_pipe_q[i][j] <= '0;
        end
      end
    end else if (state_q != ST_COMPUTE) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        for (int unsigned j = 0; j < MAX_DIM; j++) begin
          a_pipe_q[i][j] <= '0;
          b_pipe_q[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        a_pipe_q[i][0] <= row_feed_d[i];
        b_pipe_q[0][i] <= col_feed_d[i];
        for (int unsigned j = 1; j < MAX_DIM; j++) begin
          a_pipe_q[i][j] <= a_pipe_q[i][j-1];
          b_pipe_q[j][i] <= b_pipe_q[j-1][i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      ovf[i] = '0;
      for (int unsigned j = 0; j < MAX_DIM; j++) begin
        prod[i][j] = ACC_W'(a_pipe_q[i][j]) * ACC_W'(b_pipe_q[i][j]);
        sum[i][j]  = acc_q[i][j] + prod[i][j];
        ovf[i][j]  = (acc_q[i][j][ACC_W-1] == prod[i][j][ACC_W-1]) &&
                     (sum[i][j][ACC_W-1] != acc_q[i][j][ACC_W-1]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        flag_q[i] <= '0;
        for (int unsigned j = 0; j < MAX_DIM; j++) acc_q[i][j] <= '0;
      end
    end else if (start_accept && dims_legal && !accumulate_i) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        flag_q[i] <= '0;
        for (int unsigned j = 0; j < MAX_DIM; j++) acc_q[i][j] <= '0;
      end
    end else if (state_q == ST_COMPUTE) begin
      for (int unsigned i = 0; i < MAX_DIM; i++) begin
        flag_q[i] <= flag_q[i] | ovf[i];
        for (int unsigned j = 0; j < MAX_DIM; j++) acc_q[i][j] <= sum[i][j];
      end
    end
  end

  always_comb begin
    c_matrix_o = '0;
    flags_o    = '0;
    for (int unsigned i = 0; i < MAX_DIM; i++) begin
      for (int unsigned j = 0; j < MAX_DIM; j++) begin
        c_matrix_o[(i*MAX_DIM+j)*ACC_W +: ACC_W] = acc_q[i][j];
        flags_o[i*MAX_DIM+j]                     = flag_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_matmul_systolic_engine.sv
// Directed, table-driven bench for matmul_systolic_engine at MAX_DIM=4.
module tb_matmul_systolic_engine;

  typedef struct packed {
    logic [2:0]        n, k, m;
    logic              acc;
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][15:0] c;
    logic [15:0]       fl;
  } vec_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i, accumulate_i;
  logic [2:0]   n_dim_i, k_dim_i, m_dim_i;
  logic [127:0] a_matrix_i, b_matrix_i;
  logic [255:0] c_matrix_o;
  logic [15:0]  flags_o;
  logic         busy_o, done_o, err_o;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[9];
  int   ta[16], tbv[16], tc[16];

  matmul_systolic_engine #(.DATA_WIDTH(8), .BUS_WIDTH(32), .DIM_W(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .accumulate_i(accumulate_i),
    .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
    .a_matrix_i(a_matrix_i), .b_matrix_i(b_matrix_i), .c_matrix_o(c_matrix_o),
    .flags_o(flags_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input int n, input int k, input int m,
                         input bit acc, input logic [15:0] fl);
    vecs[idx].n   = 3'(n);
    vecs[idx].k   = 3'(k);
    vecs[idx].m   = 3'(m);
    vecs[idx].acc = acc;
    vecs[idx].fl  = fl;
    for (int e = 0; e < 16; e++) begin
      vecs[idx].a[e] = 8'(ta[e]);
      vecs[idx].b[e] = 8'(tbv[e]);
      vecs[idx].c[e] = 16'(tc[e]);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat, busy_cnt, lat_exp;
    bit  seen;
    lat = 0; busy_cnt = 0; seen = 0;
    lat_exp = int'(v.n) + int'(v.m) + int'(v.k) - 1;
    @(negedge clk_i);
    n_dim_i = v.n; k_dim_i = v.k; m_dim_i = v.m;
    a_matrix_i = v.a; b_matrix_i = v.b; accumulate_i = v.acc; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_matrix_i = ~v.a;
    b_matrix_i = ~v.b;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
      if (done_o) begin seen = 1; lat = c - 1; end
    end
    chk($sformatf("%s.done_seen", tag), 256'(seen), 256'(1));
    chk($sformatf("%s.latency", tag), 256'(lat), 256'(lat_exp));
    chk($sformatf("%s.busy_cycles", tag), 256'(busy_cnt), 256'(lat_exp));
    chk($sformatf("%s.busy_in_done", tag), 256'(busy_o), 256'(0));
    chk($sformatf("%s.err", tag), 256'(err_o), 256'(0));
    for (int e = 0; e < 16; e++)
      chk($sformatf("%s.c%0d", tag, e), 256'(c_matrix_o[e*16 +: 16]), 256'(v.c[e]));
    chk($sformatf("%s.flags", tag), 256'(flags_o), 256'(v.fl));
    @(negedge clk_i);
    chk($sformatf("%s.done_pulse", tag), 256'(done_o), 256'(0));
  endtask

  task automatic run_bad(input logic [2:0] n, input logic [2:0] k, input logic [2:0] m,
                         input string tag, input logic [255:0] c_exp, input logic [15:0] fl_exp);
    @(negedge clk_i);
    n_dim_i = n; k_dim_i = k; m_dim_i = m;
    a_matrix_i = '1; b_matrix_i = '1; accumulate_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk($sformatf("%s.done", tag), 256'(done_o), 256'(1));
    chk($sformatf("%s.err", tag), 256'(err_o), 256'(1));
    chk($sformatf("%s.busy", tag), 256'(busy_o), 256'(0));
    @(negedge clk_i);
    chk($sformatf("%s.done_pulse", tag), 256'(done_o), 256'(0));
    chk($sformatf("%s.busy_after", tag), 256'(busy_o), 256'(0));
    chk($sformatf("%s.c_kept", tag), c_matrix_o, c_exp);
    chk($sformatf("%s.flags_kept", tag), 256'(flags_o), 256'(fl_exp));
  endtask

  initial begin
    bit seen_done;

    // 2x2x2 reference product, then accumulate, then clear again
    ta  = '{1, 2, 0, 0,  3, 4, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbv = '{5, 6, 0, 0,  7, 8, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tc  = '{19, 22, 0, 0,  43, 50, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    set_vec(0, 2, 2, 2, 1'b0, 16'h0000);
    set_vec(2, 2, 2, 2, 1'b0, 16'h0000);
    set_vec(8, 2, 2, 2, 1'b1, 16'h0000);
    tc  = '{38, 44, 0, 0,  86, 100, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    set_vec(1, 2, 2, 2, 1'b1, 16'h0000);
    // N=3,K=1,M=4 outer product; entries outside K and N are decoys
    ta  = '{1, 9, 0, 0,  -2, 0, 0, 0,  3, 0, 0, 0,  5, 0, 0, 0};
    tbv = '{1, 2, 3, 4,  9, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tc  = '{1, 2, 3, 4,  -2, -4, -6, -8,  3, 6, 9, 12,  0, 0, 0, 0};
    set_vec(3, 3, 1, 4, 1'b0, 16'h0000);
    // K=4 of (-128)*(-128): sum 65536 wraps to 0 with overflow on the way
    for (int e = 0; e < 16; e++) begin ta[e] = -128; tbv[e] = -128; tc[e] = 0; end
    set_vec(4, 1, 4, 1, 1'b0, 16'h0001);
    ta  = '{7, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbv = '{-3, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tc  = '{-21, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    set_vec(5, 1, 1, 1, 1'b0, 16'h0000);
    // Full 4x4x4 with A = 2*I, so C = 2*B
    ta  = '{2, 0, 0, 0,  0, 2, 0, 0,  0, 0, 2, 0,  0, 0, 0, 2};
    tbv = '{-8, -7, -6, -5,  -4, -3, -2, -1,  0, 1, 2, 3,  4, 5, 6, 7};
    tc  = '{-16, -14, -12, -10,  -8, -6, -4, -2,  0, 2, 4, 6,  8, 10, 12, 14};
    set_vec(6, 4, 4, 4, 1'b0, 16'h0000);
    // 2x3x1 accumulated onto 2*B: only C[0][0], C[1][0] move (+12, +9)
    ta  = '{1, 1, 1, 0,  1, -1, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    tbv = '{3, 0, 0, 0,  4, 0, 0, 0,  5, 0, 0, 0,  0, 0, 0, 0};
    tc  = '{-4, -14, -12, -10,  1, -6, -4, -2,  0, 2, 4, 6,  8, 10, 12, 14};
    set_vec(7, 2, 3, 1, 1'b1, 16'h0000);

    rst_ni = 1'b0; start_i = 1'b0; accumulate_i = 1'b0;
    n_dim_i = '0; k_dim_i = '0; m_dim_i = '0; a_matrix_i = '0; b_matrix_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset.c", c_matrix_o, '0);
    chk("reset.flags", 256'(flags_o), 256'(0));
    chk("reset.busy_done_err", 256'({busy_o, done_o, err_o}), 256'(0));
    rst_ni = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    run_bad(3'd2, 3'd0, 3'd2, "bad_k0", vecs[7].c, 16'h0000);
    run_bad(3'd2, 3'd5, 3'd2, "bad_k5", vecs[7].c, 16'h0000);

    // Reset asserted during cycle t=2 of a 4x4x4 run
    @(negedge clk_i);
    n_dim_i = 3'd4; k_dim_i = 3'd4; m_dim_i = 3'd4;
    a_matrix_i = vecs[6].a; b_matrix_i = vecs[6].b; accumulate_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst.c", c_matrix_o, '0);
    chk("midrst.flags", 256'(flags_o), 256'(0));
    chk("midrst.busy_done_err", 256'({busy_o, done_o, err_o}), 256'(0));
    seen_done = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      if (c == 2) rst_ni = 1'b1;
      if (done_o) seen_done = 1;
    end
    chk("midrst.no_done", 256'(seen_done), 256'(0));
    run_vec(vecs[8], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
